// File: rtl/obstacle_spawner.sv
// obstacle_spawner
//   Turns the 4-bit random stream into timed obstacle spawn requests for the
//   three-lane playfield. After a random gap (counted in frame ticks) a lane is
//   picked from the random nibble, with a limit on how many spawns may land in
//   the same lane back to back, and offered to the renderer.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   rnd_data     random nibble, new value every clk
//   tick         one-cycle frame-tick pulse
//   enable       game running; low forces IDLE and drops any pending request
//   spawn_valid  request pending (registered)
//   spawn_lane   lane of the pending request, 0..2 (registered)
//   spawn_ready  renderer accepts when high together with spawn_valid
//   spawn_count  total accepted spawns, saturating at 255
//   busy         high whenever the FSM is not IDLE
//
// Handshake: a request is transferred in the cycle where spawn_valid and
// spawn_ready are both high; spawn_valid/spawn_lane hold steady until then, and
// spawn_ready is ignored while spawn_valid is low.
module obstacle_spawner #(
  parameter int GAP_MIN    = 16,
  parameter int GAP_STEP   = 8,
  parameter int MAX_REPEAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rnd_data,
  input  logic       tick,
  input  logic       enable,
  output logic       spawn_valid,
  output logic [1:0] spawn_lane,
  input  logic       spawn_ready,
  output logic [7:0] spawn_count,
  output logic       busy
);

  localparam logic [7:0] GAP_MIN_W  = 8'(GAP_MIN);
  localparam logic [7:0] GAP_STEP_W = 8'(GAP_STEP);
  localparam logic [7:0] MAX_RUN    = 8'(MAX_REPEAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] count_q, count_d;
  logic [7:0] run_q, run_d;
  logic [1:0] lane_q, lane_d;
  logic [1:0] prev_q, prev_d;
  logic       valid_q, valid_d;

  logic [7:0] gap;
  logic [1:0] cand;
  logic [1:0] pick;
  logic       handshake;

  // Gap and lane candidates are always derived from this cycle's nibble.
  assign gap  = GAP_MIN_W + 8'(rnd_data[3:2]) * GAP_STEP_W;
  // Raw value 3 is folded onto the middle lane so every nibble maps to a lane.
  assign cand = (rnd_data[1:0] == 2'd3) ? 2'd1 : rnd_data[1:0];
  // Once the previous lane has repeated MAX_REPEAT times, rotate to the next lane.
  assign pick = ((cand == prev_q) && (run_q >= MAX_RUN))
              ? ((cand == 2'd2) ? 2'd0 : cand + 2'd1)
              : cand;
  assign handshake = valid_q & spawn_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    run_d   = run_q;
    lane_d  = lane_q;
    prev_d  = prev_q;
    valid_d = valid_q;

    if (!enable) begin
      // Dropping enable wins over a same-cycle handshake: nothing is counted.
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT;
          cnt_d   = gap;
        end
        S_WAIT: begin
          if (tick) begin
            // <= 1 rather than == 1 keeps a zero count from wrapping to 255.
            if (cnt_q <= 8'd1) begin
              lane_d  = pick;
              valid_d = 1'b1;
              state_d = S_ISSUE;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
        S_ISSUE: begin
          if (handshake) begin
            count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
            if (lane_q == prev_q) begin
              run_d = (run_q >= MAX_RUN) ? MAX_RUN : run_q + 8'd1;
            end else begin
              run_d = 8'd1;
            end
            prev_d  = lane_q;
            cnt_d   = gap;
            valid_d = 1'b0;
            state_d = S_WAIT;
          end
        end
        default: begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      count_q <= 8'd0;
      run_q   <= 8'd0;
      lane_q  <= 2'd0;
      prev_q  <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      run_q   <= run_d;
      lane_q  <= lane_d;
      prev_q  <= prev_d;
      valid_q <= valid_d;
    end
  end

  assign spawn_valid = valid_q;
  assign spawn_lane  = lane_q;
  assign spawn_count = count_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/obstacle_spawner.md
Name: obstacle_spawner

Overview:
- Consumer of the 4-bit pseudo-random stream produced by the game's Random generator.
- Turns random nibbles into timed obstacle spawn requests for the On-The-Run playfield: one of three lanes, plus a randomised gap measured in frame ticks.
- Hands each request to the obstacle renderer over a valid/ready handshake.
- Sits between Random and the object/VGA drawing logic.

Parameters:
GAP_MIN, 16, minimum frame ticks between spawns (must be >= 1).
GAP_STEP, 8, extra ticks per unit of rnd_data[3:2].
MAX_REPEAT, 2, maximum consecutive spawns allowed in the same lane (>= 1).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
rnd_data  input  4  random nibble from Random; new value every clk.
tick  input  1  one-cycle frame-tick pulse; all gap counting is in ticks.
enable  input  1  game running; low forces idle.
spawn_valid  output  1  spawn request pending.
spawn_lane  output  2  lane of the pending request, 0..2.
spawn_ready  input  1  renderer accepts the request when high with spawn_valid.
spawn_count  output  8  total accepted spawns, saturating.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: state IDLE; spawn_valid 0; spawn_lane 0; spawn_count 0; gap counter 0; prev_lane 0; run 0; busy 0.
- States: IDLE, WAIT, ISSUE.
- IDLE:
  - enable=1 -> WAIT.
  - Counter loads GAP = GAP_MIN + rnd_data[3:2]*GAP_STEP, using rnd_data sampled that cycle.
  - Counter is 8 bits; defaults give a maximum of 40.
- WAIT:
  - On tick with counter != 1: decrement.
  - On tick with counter == 1: latch lane from the same-cycle rnd_data, go to ISSUE.
  - The first tick after entering WAIT counts, so exactly GAP ticks elapse before ISSUE.
  - Non-tick cycles leave the counter unchanged.
- Lane selection (at the WAIT->ISSUE edge):
  - raw = rnd_data[1:0]; cand = 1 if raw==3, else raw.
  - If cand==prev_lane and run >= MAX_REPEAT: lane = (cand==2) ? 0 : cand+1.
  - Otherwise lane = cand.
- ISSUE:
  - spawn_valid=1 and spawn_lane=lane, registered, asserted the cycle after the latching tick.
  - spawn_valid and spawn_lane stay stable until the handshake (spawn_valid & spawn_ready).
  - Ticks are ignored while in ISSUE.
- Handshake cycle:
  - spawn_count increments, saturating at 255.
  - run = (lane==prev_lane) ? run+1 : 1, saturating at MAX_REPEAT; then prev_lane = lane.
  - Counter reloads GAP from the same-cycle rnd_data; state -> WAIT; spawn_valid 0 next cycle.
- enable=0 in any state:
  - Next state IDLE; spawn_valid deasserts the next cycle; a pending request is dropped and not counted.
  - spawn_count, prev_lane and run are retained.
  - enable=0 takes priority over a simultaneous handshake: no count, no reload.
- rst in any state: all values return to reset values at the next edge, including mid-ISSUE with spawn_valid high.
- spawn_ready while spawn_valid=0 has no effect.
- busy = (state != IDLE).
- No combinational path from inputs to outputs.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, enable=0, ticks running -> spawn_valid=0, spawn_count=0, busy=0; no change over 100 ticks.
- First spawn timing: enable=1, rnd_data=4'b0000, ticks every 4 clk, spawn_ready=1 -> spawn_valid rises on the clk after the 16th tick, lane=0, spawn_count=1. Repeat with rnd_data=4'b1100 -> 40 ticks.
- Lane remap and repeat limit: rnd_data fixed at 4'b0011, MAX_REPEAT=2, spawn_ready=1 -> lanes 1,1,2,1,1,2; rnd_data fixed at 4'b0010 -> lanes 2,2,0,2,2,0.
- Backpressure: spawn_ready=0 for 50 clk with ticks continuing -> spawn_valid and spawn_lane stay constant, counter does not advance. Raising spawn_ready for 1 clk -> count +1, spawn_valid=0 the next clk, next spawn exactly GAP ticks later.
- Enable drop:
  - Deassert enable mid-WAIT -> IDLE next clk, busy=0, count unchanged.
  - Deassert enable in ISSUE with spawn_ready=1 that same cycle -> no count increment, spawn_valid=0 next clk.
  - Re-enable -> full new GAP.
- Saturation and reset: 300 accepted spawns (GAP_MIN=1, GAP_STEP=0 build) -> spawn_count holds 255. Assert rst while spawn_valid=1 -> next clk spawn_valid=0, spawn_count=0, state IDLE.
